// File: rtl/mac_pe_simd.sv
// mac_pe_simd: multi-lane multiply-accumulate processing element for the
// systolic array. Each accepted beat multiplies LANES data/weight pairs,
// sums the products and adds the sum to an accumulator. After `len` beats
// the accumulator (plus an optional upstream partial sum) is drained to the
// result collector over a valid/ready handshake.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, len                  begin a result of `len` beats (IDLE only)
//   signed_mode, saturate_en    operand/accumulation mode, sampled at start
//   abort                       synchronous cancel back to IDLE
//   in_valid/in_ready           operand beat handshake
//   data_in, weight_in          packed lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   partial_sum_in, use_partial_sum  upstream partial sum added at drain
//   data_out, weight_out, fwd_valid  registered copy of each accepted beat
//   result_out, overflow_out    final result and its sticky overflow flag
//   out_valid/out_ready         result handshake
//   busy                        high whenever not IDLE
module mac_pe_simd #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        len,
  input  logic                        signed_mode,
  input  logic                        saturate_en,
  input  logic                        abort,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] data_in,
  input  logic [LANES*DATA_WIDTH-1:0] weight_in,
  input  logic [ACC_WIDTH-1:0]        partial_sum_in,
  input  logic                        use_partial_sum,
  output logic [LANES*DATA_WIDTH-1:0] data_out,
  output logic [LANES*DATA_WIDTH-1:0] weight_out,
  output logic                        fwd_valid,
  output logic [ACC_WIDTH-1:0]        result_out,
  output logic                        overflow_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = ACC_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

  state_t                      state, state_nxt;
  logic [CNT_WIDTH-1:0]        cnt;
  logic                        flush_cnt;
  logic                        signed_q, sat_q;
  logic                        ovf_acc;
  logic                        vld_p1;
  logic signed [SW-1:0]        lane_sum_p1;
  logic signed [ACC_WIDTH-1:0] acc_p2;

  logic                        accept, start_ok, drain_load;
  logic signed [SW-1:0]        lane_sum;
  logic [SW-1:0]               psum_ext;
  logic [ACC_WIDTH:0]          acc_add, res_add;

  logic [DATA_WIDTH-1:0]       d_lane, w_lane;
  logic signed [DATA_WIDTH:0]  d_ext, w_ext;
  logic signed [PW+1:0]        prod;

  // Adds an ACC_WIDTH accumulator to an already-extended ACC_WIDTH+1 addend.
  // Returns {overflow, value}; value is clamped when sat is set, else wrapped.
  function automatic logic [ACC_WIDTH:0] sat_add(
    input logic [ACC_WIDTH-1:0] a,
    input logic [SW-1:0]        b,
    input logic                 sgn,
    input logic                 sat
  );
    logic [SW-1:0]        a_ext, sum;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] val;
    a_ext = {sgn & a[ACC_WIDTH-1], a};
    sum   = a_ext + b;
    // Signed: the extra bit disagrees with the sign bit. Unsigned: carry out.
    ovf   = sgn ? (sum[SW-1] != sum[SW-2]) : sum[SW-1];
    val   = sum[ACC_WIDTH-1:0];
    if (sat && ovf) begin
      if (!sgn)          val = '1;
      else if (sum[SW-1]) val = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else               val = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return {ovf, val};
  endfunction

  assign accept     = (state == ACCUM) && in_valid && !abort;
  assign start_ok   = (state == IDLE) && start && !abort;
  assign drain_load = (state == FLUSH) && flush_cnt && !abort;

  // Each lane operand gets one extra bit (sign or zero) so a single signed
  // multiplier serves both modes; the product always fits in PW+1 bits.
  always_comb begin
    lane_sum = '0;
    d_lane   = '0;
    w_lane   = '0;
    d_ext    = '0;
    w_ext    = '0;
    prod     = '0;
    for (int i = 0; i < LANES; i++) begin
      d_lane   = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      w_lane   = weight_in[i*DATA_WIDTH +: DATA_WIDTH];
      d_ext    = {signed_q & d_lane[DATA_WIDTH-1], d_lane};
      w_ext    = {signed_q & w_lane[DATA_WIDTH-1], w_lane};
      prod     = (PW+2)'(d_ext) * (PW+2)'(w_ext);
      lane_sum = lane_sum + SW'(prod);
    end
  end

  assign psum_ext = use_partial_sum ? {signed_q & partial_sum_in[ACC_WIDTH-1], partial_sum_in} : '0;
  assign acc_add  = sat_add(acc_p2, lane_sum_p1, signed_q, sat_q);
  assign res_add  = sat_add(acc_p2, psum_ext, signed_q, sat_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = (len == '0) ? FLUSH : ACCUM;
        ACCUM:   if (accept && cnt == CNT_WIDTH'(1)) state_nxt = FLUSH;
        FLUSH:   if (flush_cnt) state_nxt = DRAIN;
        DRAIN:   if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DRAIN);
    busy      = (state != IDLE);
  end

  // Stage 0 -> 1: beat acceptance, control and forwarding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      flush_cnt    <= 1'b0;
      signed_q     <= 1'b0;
      sat_q        <= 1'b0;
      ovf_acc      <= 1'b0;
      vld_p1       <= 1'b0;
      data_out     <= '0;
      weight_out   <= '0;
      result_out   <= '0;
      overflow_out <= 1'b0;
    end else begin
      vld_p1    <= accept;
      // Marks the second FLUSH cycle.
      flush_cnt <= (state == FLUSH) && !flush_cnt && !abort;
      if (accept) begin
        data_out   <= data_in;
        weight_out <= weight_in;
      end
      if (abort) begin
        cnt          <= '0;
        ovf_acc      <= 1'b0;
        overflow_out <= 1'b0;
      end else if (start_ok) begin
        cnt      <= len;
        ovf_acc  <= 1'b0;
        signed_q <= signed_mode;
        sat_q    <= saturate_en;
      end else begin
        if (accept) cnt <= cnt - CNT_WIDTH'(1);
        if (vld_p1) ovf_acc <= ovf_acc | acc_add[ACC_WIDTH];
        if (drain_load) begin
          result_out   <= res_add[ACC_WIDTH-1:0];
          overflow_out <= ovf_acc | res_add[ACC_WIDTH];
        end
      end
    end
  end

  // Stage 1 -> 2: lane sum capture and accumulation
  always_ff @(posedge clk) begin
    if (accept) lane_sum_p1 <= lane_sum;
    if (abort || start_ok) acc_p2 <= '0;
    else if (vld_p1)       acc_p2 <= acc_add[ACC_WIDTH-1:0];
  end

  assign fwd_valid = vld_p1;

endmodule
